// File: rtl/mt9v034_pkg.sv
// mt9v034_pkg: shared types and constants for the MT9V034 I2C target.
// States, device address and ACK/NACK bus levels.
package mt9v034_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_MSB,
    ST_WR_MSB_ACK,
    ST_WR_LSB,
    ST_WR_LSB_ACK,
    ST_RD_MSB,
    ST_RD_LSB
  } i2c_state_e;

  localparam logic [6:0] MT9V034_I2C_ADDR = 7'h5C;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-FF synchronizer for one I2C line, plus an
// optional glitch filter enabled by I2C_GLITCH_FILTER_EN.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic line_out
);

  logic [1:0] sync;

  // two-flop synchronizer; an idle I2C line sits high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], line_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif

  // a length of 1 needs no counter: every sample is already stable
  if (FILT_ON && FILTER_LEN > 1) begin : g_filt
    localparam int CW = $clog2(FILTER_LEN);

    logic [CW-1:0] cnt;
    logic          lvl;

    // level follows the line only after FILTER_LEN equal samples
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b1;
      end else if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        cnt <= '0;
        lvl <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign line_out = lvl;
  end else begin : g_bypass
    assign line_out = sync[1];
  end

endmodule

// File: rtl/mt9v034_i2c_target.sv
// mt9v034_i2c_target: I2C target mimicking the MT9V034 control bus.
// Optional input glitch filter: define I2C_GLITCH_FILTER_EN.
module mt9v034_i2c_target
  import mt9v034_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = MT9V034_I2C_ADDR,
  parameter int         FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [15:0] reg_rdata,
  output logic        busy
);

  i2c_state_e state;

  logic       scl;
  logic       sda;
  logic       scl_q;
  logic       sda_q;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_c;
  logic       stop_c;
  logic       rx_st;
  logic       byte_end;
  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] byte_in;
  logic [7:0] wmsb;
  logic [15:0] tx;
  logic       rw;
  logic       re_d;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clk      (clk),
    .reset    (reset),
    .line_in  (scl_in),
    .line_out (scl)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clk      (clk),
    .reset    (reset),
    .line_in  (sda_in),
    .line_out (sda)
  );

  // previous line levels for edge and START/STOP detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start_c  = scl & scl_q & sda_q & ~sda;
  assign stop_c   = scl & scl_q & ~sda_q & sda;
  assign byte_in  = {shreg, sda};
  assign rx_st    = state inside {ST_DEV_ADDR, ST_REG_ADDR,
                                  ST_WR_MSB, ST_WR_LSB};
  assign byte_end = rx_st & scl_rise & (bit_cnt == 4'd7);

  // protocol FSM; START/STOP win over bit handling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      wmsb      <= '0;
      tx        <= '0;
      rw        <= 1'b0;
      re_d      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      re_d   <= reg_re;
      if (reg_we) reg_addr <= reg_addr + 8'd1;
      if (re_d) tx <= reg_rdata;

      if (stop_c) begin
        state   <= ST_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_c) begin
        state   <= ST_DEV_ADDR;
        bit_cnt <= '0;
      end else begin
        if (rx_st) begin
          if (scl_fall) sda_oe <= 1'b0;
          if (scl_rise) begin
            shreg   <= byte_in[6:0];
            bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
          end
        end

        case (state)
          ST_DEV_ADDR: begin
            if (byte_end) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                state  <= ST_DEV_ACK;
                busy   <= 1'b1;
                rw     <= byte_in[0];
                reg_re <= byte_in[0];
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
          ST_REG_ADDR: begin
            if (byte_end) begin
              reg_addr <= byte_in;
              state    <= ST_REG_ACK;
            end
          end
          ST_WR_MSB: begin
            if (byte_end) begin
              wmsb  <= byte_in;
              state <= ST_WR_MSB_ACK;
            end
          end
          ST_WR_LSB: begin
            if (byte_end) begin
              reg_wdata <= {wmsb, byte_in};
              reg_we    <= 1'b1;
              state     <= ST_WR_LSB_ACK;
            end
          end
          ST_DEV_ACK, ST_REG_ACK,
          ST_WR_MSB_ACK, ST_WR_LSB_ACK: begin
            if (scl_fall) sda_oe <= ~ACK;
            if (scl_rise) begin
              bit_cnt <= '0;
              unique case (1'b1)
                state == ST_DEV_ACK:
                  state <= rw ? ST_RD_MSB : ST_REG_ADDR;
                state == ST_REG_ACK:    state <= ST_WR_MSB;
                state == ST_WR_MSB_ACK: state <= ST_WR_LSB;
                default:                state <= ST_WR_MSB;
              endcase
            end
          end
          ST_RD_MSB, ST_RD_LSB: begin
            if (scl_fall) begin
              if (bit_cnt < 4'd8) begin
                sda_oe <= ~tx[15];
                tx     <= {tx[14:0], 1'b0};
              end else begin
                sda_oe <= 1'b0;
              end
            end
            if (scl_rise) begin
              if (bit_cnt != 4'd8) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (state == ST_RD_LSB && bit_cnt == 4'd7)
                  reg_addr <= reg_addr + 8'd1;
              end else begin
                bit_cnt <= '0;
                if (sda == NACK) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                end else if (state == ST_RD_MSB) begin
                  state <= ST_RD_LSB;
                end else begin
                  state  <= ST_RD_MSB;
                  reg_re <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
